game_frame_tx: RTL

//  Parametrised game-state frame transmitter for the board-to-board UART link.

---
 rtl/game_frame_tx_if.sv | 10 +
 rtl/game_frame_tx.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/game_frame_tx_if.sv
// game_frame_tx_if: byte-write handshake between the frame transmitter and the UART TX FIFO.
// master = transmitter (drives data/strobe), slave = FIFO side (drives full flag).
interface game_frame_tx_if;
   logic [7:0] uart_data;
   logic       uart_wr;
   logic       tx_full;

   modport master (output uart_data, output uart_wr, input tx_full);
   modport slave  (input uart_data, input uart_wr, output tx_full);
endinterface

// File: rtl/game_frame_tx.sv
// game_frame_tx: game-state frame transmitter for the board-to-board UART link.
// Frame = SYNC, SEQ, NUM_BYTES payload bytes (byte 0 first), checksum over SEQ+payload.
// Frames start periodically (PERIOD_CYCLES while enabled) or on send_req; triggers that
// arrive mid-frame merge into one pending frame. Writes stall while the FIFO is full.
// Build option: define GAME_FRAME_CRC8_EN for a CRC-8 (poly 0x07, init 0) checksum;
// without it the checksum is the XOR of SEQ and all payload bytes.
module game_frame_tx #(
   parameter int          NUM_BYTES     = 8,
   parameter int          PERIOD_CYCLES = 65000,
   parameter logic [7:0]  SYNC_BYTE     = 8'hA5
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic                   send_req,
   input  logic [NUM_BYTES*8-1:0] payload_in,
   game_frame_tx_if.master        uart,
   output logic                   busy,
   output logic                   frame_sent,
   output logic [7:0]             seq_out
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_HDR  = 3'd1;
   localparam logic [2:0] S_SEQ  = 3'd2;
   localparam logic [2:0] S_PAY  = 3'd3;
   localparam logic [2:0] S_CHK  = 3'd4;
   localparam logic [2:0] S_DONE = 3'd5;

   localparam int CW = $clog2(PERIOD_CYCLES);
   localparam int IW = $clog2(NUM_BYTES + 1);

   logic [2:0]             r_state;
   logic [CW-1:0]          r_cnt;
   logic                   r_pending;
   logic [NUM_BYTES*8-1:0] r_pay;
   logic [IW-1:0]          r_idx;
   logic [7:0]             r_chk;
   logic [7:0]             r_seq;

   logic                   w_per_trig;
   logic                   w_trig;
   logic                   w_start;
   logic                   w_emit;
   logic                   w_wr;
   logic [7:0]             w_byte;
   logic [7:0]             w_chk_next;

`ifdef GAME_FRAME_CRC8_EN
   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
      logic [7:0] c;
      c = crc ^ data;
      for (int unsigned i = 0; i < 8; i++)
         c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      return c;
   endfunction
`endif

   // Trigger decode, byte-emit decode and output byte selection
   always_comb begin
      w_per_trig = enable && (r_cnt == CW'(PERIOD_CYCLES - 1));
      w_trig     = w_per_trig || (send_req && enable);
      w_start    = (r_state == S_IDLE) && enable && (w_trig || r_pending);
      w_emit     = (r_state == S_HDR) || (r_state == S_SEQ) ||
                   (r_state == S_PAY) || (r_state == S_CHK);
      w_wr       = w_emit && !uart.tx_full;
      case (r_state)
         S_HDR:   w_byte = SYNC_BYTE;
         S_SEQ:   w_byte = r_seq;
         S_PAY:   w_byte = r_pay[7:0];
         S_CHK:   w_byte = r_chk;
         default: w_byte = '0;
      endcase
`ifdef GAME_FRAME_CRC8_EN
      w_chk_next = crc8_step(r_chk, w_byte);
`else
      w_chk_next = r_chk ^ w_byte;
`endif
   end

   assign uart.uart_data = w_byte;
   assign uart.uart_wr   = w_wr;
   assign busy           = (r_state != S_IDLE);
   assign frame_sent     = (r_state == S_DONE);
   assign seq_out        = r_seq;

   // Auto-send interval counter, held at zero while the link is disabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (!enable || w_per_trig)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + 1'b1;
   end

   // One-bit pending flag: triggers during a frame collapse into a single follow-up frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_pending <= 1'b0;
      else if (!enable || w_start)
         r_pending <= 1'b0;
      else if ((r_state != S_IDLE) && w_trig)
         r_pending <= 1'b1;
   end

   // Frame sequencer: payload is shifted out LSB byte first, checksum accumulated per write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_pay   <= '0;
         r_idx   <= '0;
         r_chk   <= '0;
         r_seq   <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (w_start) begin
               r_pay   <= payload_in;
               r_idx   <= '0;
               r_chk   <= '0;
               r_state <= S_HDR;
            end
            S_HDR: if (w_wr) r_state <= S_SEQ;
            S_SEQ: if (w_wr) begin
               r_chk   <= w_chk_next;
               r_state <= S_PAY;
            end
            S_PAY: if (w_wr) begin
               r_chk <= w_chk_next;
               r_pay <= r_pay >> 8;
               if (r_idx == IW'(NUM_BYTES - 1))
                  r_state <= S_CHK;
               else
                  r_idx <= r_idx + 1'b1;
            end
            S_CHK: if (w_wr) r_state <= S_DONE;
            S_DONE: begin
               r_seq   <= r_seq + 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
